uart_transmitter: RTL and testbench

Serialises bytes onto a single UART line: 8N1 framing, LSB first, idle-high, fixed CLKS_PER_BIT baud divider. It is the transmit half paired with the on-FPGA UART receiver and carries order/response bytes from fabric logic back to the host. Upstream logic hands bytes over through a valid/ready handshake. The block holds one byte at a time; it has no FIFO.

---
 rtl/uart_tx_if.sv | 31 +++
 rtl/uart_transmitter.sv | 185 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handoff between fabric logic and the UART transmitter.
//
// Handshake: a byte transfers on a rising clk edge where tx_valid and
// tx_ready are both high. The master holds tx_valid and tx_data stable until
// that edge. tx_ready does not depend on tx_valid, and the slave samples
// tx_data only at the transfer edge.
//
// Signals:
//   tx_valid  master -> slave  byte on tx_data is offered
//   tx_data   master -> slave  byte to transmit (8 bits)
//   tx_ready  slave -> master  slave accepts a byte on this edge
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises one byte at a time onto a UART line: 8N1, LSB first, idle high,
// fixed CLKS_PER_BIT clocks per bit. Holds a single byte; no FIFO.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// data bit 7 and the stop bit (even when PARITY_ODD = 0, odd when 1).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, must be >= 2
//   PARITY_ODD    parity sense when UART_TX_PARITY_EN is defined
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        uart_tx_if slave: tx_valid / tx_data in, tx_ready out
//   tx_out     serial line, idle high
//   tx_busy    high while a frame is being shifted out
//   tx_done    one-cycle pulse on the first idle cycle after a frame
//   dbg_state  current FSM state encoding, for observation only
//
// All outputs are registered: the comb process computes the next state and
// the next output values from it, and the register process stores both.
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 127,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_tx_if.slave   bus,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    // Guarded so an illegal CLKS_PER_BIT reaches the $error below instead of
    // failing on a zero-width counter first.
    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
    end

    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_B = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY  = 3'd4
`endif
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       idx_q, idx_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             tx_ready_q;
    logic             out_nxt;
    logic             done_nxt;
    logic             bit_last;

    // High on the final clock of the current serial bit.
    assign bit_last = (cnt_q == CNT_LAST);

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
    // XOR of the data gives the even-parity bit; odd parity inverts it.
    assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);
`endif

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        out_nxt   = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (bus.tx_valid && tx_ready_q) begin
                    data_nxt  = bus.tx_data;
                    state_nxt = START_B;
                end
            end
            START_B: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_nxt = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx_q + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase

        // Line level for the cycle after this edge, derived from where the
        // FSM is going so the registered tx_out lines up with the state.
        case (state_nxt)
            START_B: out_nxt = 1'b0;
            DATA:    out_nxt = data_nxt[idx_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_nxt = parity_bit;
`endif
            default: out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            tx_out     <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            idx_q      <= idx_nxt;
            data_q     <= data_nxt;
            tx_out     <= out_nxt;
            tx_ready_q <= (state_nxt == IDLE);
            tx_busy    <= (state_nxt != IDLE);
            tx_done    <= done_nxt;
        end
    end

    assign bus.tx_ready = tx_ready_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Self-checking bench for uart_transmitter at CLKS_PER_BIT = 4. The reference
// model describes each clock after acceptance as one entry
// {line, ready, busy, done}, built from the frame's bit list (start, data LSB
// first, optional parity, stop) each held C clocks, followed by idle cycles.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int C          = 4;
    localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] dbg_state;

    uart_tx_if bus ();

    uart_transmitter #(
        .CLKS_PER_BIT (C),
        .PARITY_ODD   (PARITY_ODD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];   // {line, ready, busy, done} per clock
    logic [3:0] obs_q[$];

    // ---------------- reference model ----------------
`ifdef UART_TX_PARITY_EN
    function automatic logic parity_of(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        if (PARITY_ODD == 0) return (ones % 2) == 1;
        else                 return (ones % 2) == 0;
    endfunction
`endif

    function automatic void model_frame(input logic [7:0] b);
        logic bits_q[$];
        bits_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits_q.push_back(parity_of(b));
`endif
        bits_q.push_back(1'b1);
        foreach (bits_q[k])
            for (int j = 0; j < C; j++) exp_q.push_back({bits_q[k], 1'b0, 1'b1, 1'b0});
    endfunction

    // n idle cycles; the first carries tx_done when it follows a frame.
    function automatic void model_idle(input int n, input bit after_frame);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b1, 1'b1, 1'b0, (after_frame && i == 0)});
    endfunction

    // ---------------- driver / monitor tasks ----------------
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_q.push_back({tx_out, bus.tx_ready, tx_busy, tx_done});
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        @(negedge clk);
        total++;
        if ({tx_out, bus.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_hold out/ready/busy/done got %b exp 1100",
                     {tx_out, bus.tx_ready, tx_busy, tx_done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_queues();
        model_idle(50, 1'b0);
        capture(50);
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reset_idle[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_single_a5();
        int dones;
        clear_queues();
        model_frame(8'hA5);
        model_idle(2, 1'b1);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        fork
            capture(exp_q.size());
            begin
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_a5[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
        // Start bit on the first cycle after acceptance.
        total++;
        if (obs_q[0][3] !== 1'b0) begin
            bad++;
            $display("FAIL single_a5_start got %b exp 0", obs_q[0][3]);
        end
        // Exactly one tx_done, on cycle FRAME+1 after acceptance.
        dones = 0;
        foreach (obs_q[i]) if (obs_q[i][0] === 1'b1) dones++;
        total++;
        if (dones != 1 || obs_q[FRAME][0] !== 1'b1) begin
            bad++;
            $display("FAIL single_a5_done count=%0d at_cycle_%0d=%b exp count=1 at=1",
                     dones, FRAME + 1, obs_q[FRAME][0]);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        clear_queues();
        model_frame(8'h00);
        model_idle(1, 1'b1);
        model_frame(8'hFF);
        model_idle(2, 1'b1);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        fork
            capture(exp_q.size());
            begin
                @(negedge clk);
                bus.tx_data = 8'hFF;
                repeat (FRAME + 1) @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
        dones = 0;
        foreach (obs_q[i]) if (obs_q[i][0] === 1'b1) dones++;
        total++;
        if (dones != 2) begin
            bad++;
            $display("FAIL b2b_done_count got %0d exp 2", dones);
        end
    endtask

    task automatic test_data_change();
        clear_queues();
        model_frame(8'h81);
        model_idle(2, 1'b1);
        bus.tx_data  = 8'h81;
        bus.tx_valid = 1'b1;
        fork
            capture(exp_q.size());
            begin
                for (int c = 1; c < FRAME; c++) begin
                    @(negedge clk);
                    bus.tx_data  = 8'h3C;
                    bus.tx_valid = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL data_change[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.tx_data  = 8'h70;   // bit 3 is 0, so the async rise is visible
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (4 * C + 1) @(negedge clk);   // middle of data bit 3
        total++;
        if ({tx_out, tx_busy} !== 2'b01) begin
            bad++;
            $display("FAIL mid_reset_bit3 out/busy got %b exp 01", {tx_out, tx_busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_out, bus.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL mid_reset_async got %b exp 1100",
                     {tx_out, bus.tx_ready, tx_busy, tx_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({tx_out, bus.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL mid_reset_release got %b exp 1100",
                     {tx_out, bus.tx_ready, tx_busy, tx_done});
        end
        clear_queues();
        model_frame(8'h55);
        model_idle(2, 1'b1);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        fork
            capture(exp_q.size());
            begin
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL after_reset_55[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] bytes_a[8];
        int         gaps_a[8];
        clear_queues();
        for (int k = 0; k < 8; k++) begin
            bytes_a[k] = 8'($urandom);
            gaps_a[k]  = $urandom_range(0, 3);
            model_frame(bytes_a[k]);
            model_idle(1 + gaps_a[k], 1'b1);
        end
        fork
            capture(exp_q.size());
            begin
                for (int k = 0; k < 8; k++) begin
                    bus.tx_data  = bytes_a[k];
                    bus.tx_valid = 1'b1;
                    @(negedge clk);
                    bus.tx_valid = 1'b0;
                    bus.tx_data  = 8'($urandom);
                    repeat (FRAME + gaps_a[k]) @(negedge clk);
                end
            end
        join
        foreach (exp_q[i]) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random[%0d] got %b exp %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals[2];
        logic       par_exp[2];
        vals[0] = 8'hA5; par_exp[0] = 1'b0;
        vals[1] = 8'h07; par_exp[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            clear_queues();
            model_frame(vals[v]);
            model_idle(2, 1'b1);
            bus.tx_data  = vals[v];
            bus.tx_valid = 1'b1;
            fork
                capture(exp_q.size());
                begin
                    @(negedge clk);
                    bus.tx_valid = 1'b0;
                end
            join
            foreach (exp_q[i]) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL parity_frame_%0d[%0d] got %b exp %b", v, i, obs_q[i], exp_q[i]);
                end
            end
            total++;
            if (obs_q[9 * C + 1][3] !== par_exp[v]) begin
                bad++;
                $display("FAIL parity_bit_%0d got %b exp %b", v, obs_q[9 * C + 1][3], par_exp[v]);
            end
            total++;
            if (obs_q[44][0] !== 1'b1 || obs_q[43][0] !== 1'b0) begin
                bad++;
                $display("FAIL parity_len_%0d done@45=%b done@44=%b exp 1 and 0",
                         v, obs_q[44][0], obs_q[43][0]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
